// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the regfile_sb register file: read ports,
// write ports and the busy-scoreboard issue/flush controls.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NR     = 2,
  parameter int NW     = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NR*AW-1:0]     ra;
  logic [NR*DATA_W-1:0] rd;
  logic [NR-1:0]        rd_busy;
  logic [NW-1:0]        we;
  logic [NW*AW-1:0]     wa;
  logic [NW*DATA_W-1:0] wd;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;
  logic                 flush;

  modport master (
    output ra, we, wa, wd, issue_valid, issue_addr, flush,
    input  rd, rd_busy
  );

  modport slave (
    input  ra, we, wa, wd, issue_valid, issue_addr, flush,
    output rd, rd_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and a per-register
// busy scoreboard that lets decode stall on outstanding multi-cycle producers.
module regfile_sb #(
  parameter int  DATA_W = 32,
  parameter int  NREGS  = 32,
  parameter int  NR     = 2,
  parameter int  NW     = 1,
  parameter int  BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         resetn,
  regfile_sb_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;

  // Writes applied in ascending port order so the highest-index port wins.
  always_comb begin
    // NOTE: blocking assignments in combinational logic, starting from the held
    // value, so every path assigns the whole array and no latch is inferred.
    regs_d = regs_q;
    for (int j = 0; j < NW; j++) begin
      if (bus.we[j] && bus.wa[j*AW +: AW] != '0) begin
        regs_d[bus.wa[j*AW +: AW]] = bus.wd[j*DATA_W +: DATA_W];
      end
    end
    regs_d[0] = '0;
  end

  // Later assignments override earlier ones: write-clear, then issue, then flush.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (bus.we[j]) begin
        busy_d[bus.wa[j*AW +: AW]] = 1'b0;
      end
    end
    if (bus.issue_valid) begin
      busy_d[bus.issue_addr] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: the register array is reset because software may read any register
  // before writing it and must see zero; flops use non-blocking assignments.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Reads are combinational; outputs are forced quiet while reset is held so a
  // bypassed write cannot leak through.
  always_comb begin
    bus.rd      = '0;
    bus.rd_busy = '0;
    rd_addr     = '0;
    rd_data     = '0;
    rd_hit      = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rd_addr = bus.ra[i*AW +: AW];
      rd_data = regs_q[rd_addr];
      rd_hit  = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NW; j++) begin
          if (bus.we[j] && bus.wa[j*AW +: AW] == rd_addr) begin
            rd_data = bus.wd[j*DATA_W +: DATA_W];
            rd_hit  = 1'b1;
          end
        end
      end
      if (resetn && rd_addr != '0) begin
        bus.rd[i*DATA_W +: DATA_W] = rd_data;
        bus.rd_busy[i]             = busy_q[rd_addr] & ~rd_hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a committed-only 2R1W instance and a bypassing 4R2W
// instance, checked every cycle against an array model plus literal pins.
module tb_regfile_sb;
  localparam int DW    = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .NREGS(NREGS), .NR(2), .NW(1)) if0 ();
  regfile_sb_if #(.DATA_W(DW), .NREGS(NREGS), .NR(4), .NW(2)) if1 ();

  regfile_sb #(.DATA_W(DW), .NREGS(NREGS), .NR(2), .NW(1), .BYPASS(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(if0)
  );
  regfile_sb #(.DATA_W(DW), .NREGS(NREGS), .NR(4), .NW(2), .BYPASS(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1)
  );

  // Stimulus, indexed [dut][port]
  logic [AW-1:0] s_ra [2][4];
  logic          s_we [2][2];
  logic [AW-1:0] s_wa [2][2];
  logic [DW-1:0] s_wd [2][2];
  logic          s_iv [2];
  logic [AW-1:0] s_ia [2];
  logic          s_fl [2];

  logic [DW-1:0] o_rd   [2][4];
  logic          o_busy [2][4];

  always_comb begin
    if0.ra          = {s_ra[0][1], s_ra[0][0]};
    if0.we          = s_we[0][0];
    if0.wa          = s_wa[0][0];
    if0.wd          = s_wd[0][0];
    if0.issue_valid = s_iv[0];
    if0.issue_addr  = s_ia[0];
    if0.flush       = s_fl[0];
    if1.ra          = {s_ra[1][3], s_ra[1][2], s_ra[1][1], s_ra[1][0]};
    if1.we          = {s_we[1][1], s_we[1][0]};
    if1.wa          = {s_wa[1][1], s_wa[1][0]};
    if1.wd          = {s_wd[1][1], s_wd[1][0]};
    if1.issue_valid = s_iv[1];
    if1.issue_addr  = s_ia[1];
    if1.flush       = s_fl[1];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      o_rd[0][i]   = '0;
      o_busy[0][i] = 1'b0;
      o_rd[1][i]   = if1.rd[i*DW +: DW];
      o_busy[1][i] = if1.rd_busy[i];
    end
    for (int i = 0; i < 2; i++) begin
      o_rd[0][i]   = if0.rd[i*DW +: DW];
      o_busy[0][i] = if0.rd_busy[i];
    end
  end

  function automatic int nr_of(int d);
    return (d == 1) ? 4 : 2;
  endfunction

  function automatic int nw_of(int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // Architectural model: register contents and busy set per instance
  logic [DW-1:0] m_regs [2][NREGS];
  logic          m_busy [2][NREGS];

  always @(posedge clk) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < NREGS; r++) begin
          m_regs[d][r] <= '0;
          m_busy[d][r] <= 1'b0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int j = 0; j < nw_of(d); j++) begin
          if (s_we[d][j] && s_wa[d][j] != 0) m_regs[d][s_wa[d][j]] <= s_wd[d][j];
        end
        if (s_fl[d]) begin
          for (int r = 0; r < NREGS; r++) m_busy[d][r] <= 1'b0;
        end else begin
          for (int j = 0; j < nw_of(d); j++) begin
            if (s_we[d][j]) m_busy[d][s_wa[d][j]] <= 1'b0;
          end
          if (s_iv[d] && s_ia[d] != 0) m_busy[d][s_ia[d]] <= 1'b1;
        end
      end
    end
  end

  function automatic void model_read(input int d, input int i,
                                     output logic [DW-1:0] v, output logic b);
    logic [AW-1:0] a;
    logic          hit;
    a   = s_ra[d][i];
    hit = 1'b0;
    v   = m_regs[d][a];
    b   = m_busy[d][a];
    if (d == 1) begin
      for (int j = 0; j < nw_of(d); j++) begin
        if (s_we[d][j] && s_wa[d][j] == a) begin
          v   = s_wd[d][j];
          hit = 1'b1;
        end
      end
    end
    if (hit) b = 1'b0;
    if (a == 0 || !resetn) begin
      v = '0;
      b = 1'b0;
    end
  endfunction

  // Hand-computed expectations for selected cycles
  logic          pin_on [2][4];
  logic [DW-1:0] pin_rd [2][4];
  logic          pin_b  [2][4];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] ev;
    logic          eb;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < nr_of(d); i++) begin
        model_read(d, i, ev, eb);
        check($sformatf("dut%0d_rd%0d", d, i), o_rd[d][i], ev);
        check($sformatf("dut%0d_busy%0d", d, i), DW'(o_busy[d][i]), DW'(eb));
        if (pin_on[d][i]) begin
          check($sformatf("pin_dut%0d_rd%0d", d, i), o_rd[d][i], pin_rd[d][i]);
          check($sformatf("pin_dut%0d_busy%0d", d, i), DW'(o_busy[d][i]), DW'(pin_b[d][i]));
          check($sformatf("pin_model%0d_rd%0d", d, i), ev, pin_rd[d][i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) pin_on[d][i] = 1'b0;
      for (int j = 0; j < 2; j++) s_we[d][j] = 1'b0;
      s_iv[d] = 1'b0;
      s_fl[d] = 1'b0;
    end
  endtask

  task automatic pin(input int d, input int i, input logic [DW-1:0] v, input logic b);
    pin_on[d][i] = 1'b1;
    pin_rd[d][i] = v;
    pin_b[d][i]  = b;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        s_ra[d][i]   = '0;
        pin_on[d][i] = 1'b0;
        pin_rd[d][i] = '0;
        pin_b[d][i]  = 1'b0;
      end
      for (int j = 0; j < 2; j++) begin
        s_we[d][j] = 1'b0;
        s_wa[d][j] = '0;
        s_wd[d][j] = '0;
      end
      s_iv[d] = 1'b0;
      s_ia[d] = '0;
      s_fl[d] = 1'b0;
    end
    resetn = 1'b0;

    step();
    s_ra[0][0] = 5'd5; pin(0, 0, 32'h0, 1'b0);
    step();
    resetn = 1'b1;

    // Committed-only instance: write visible the cycle after the edge; r0 ignores writes
    step();
    s_we[0][0] = 1'b1; s_wa[0][0] = 5'd3; s_wd[0][0] = 32'hDEADBEEF;
    s_ra[0][0] = 5'd3; pin(0, 0, 32'h0, 1'b0);
    step();
    pin(0, 0, 32'hDEADBEEF, 1'b0);
    s_we[0][0] = 1'b1; s_wa[0][0] = 5'd0; s_wd[0][0] = 32'hFFFFFFFF;
    s_ra[0][1] = 5'd0; pin(0, 1, 32'h0, 1'b0);
    step();
    pin(0, 1, 32'h0, 1'b0);

    // Bypass with both write ports on r7: port 1 wins
    step();
    s_we[1][0] = 1'b1; s_wa[1][0] = 5'd7; s_wd[1][0] = 32'h11;
    s_we[1][1] = 1'b1; s_wa[1][1] = 5'd7; s_wd[1][1] = 32'h22;
    s_ra[1][0] = 5'd7; pin(1, 0, 32'h22, 1'b0);
    step();
    pin(1, 0, 32'h22, 1'b0);

    // Scoreboard: issue r9, busy for two cycles, bypassed write clears it
    step();
    s_iv[1] = 1'b1; s_ia[1] = 5'd9;
    s_ra[1][1] = 5'd9; pin(1, 1, 32'h0, 1'b0);
    step();
    pin(1, 1, 32'h0, 1'b1);
    step();
    pin(1, 1, 32'h0, 1'b1);
    step();
    s_we[1][0] = 1'b1; s_wa[1][0] = 5'd9; s_wd[1][0] = 32'h55;
    pin(1, 1, 32'h55, 1'b0);
    step();
    pin(1, 1, 32'h55, 1'b0);

    // Issue beats a same-cycle write; flush beats issue
    step();
    s_iv[1] = 1'b1; s_ia[1] = 5'd4;
    s_we[1][1] = 1'b1; s_wa[1][1] = 5'd4; s_wd[1][1] = 32'h10;
    s_ra[1][2] = 5'd4; pin(1, 2, 32'h10, 1'b0);
    step();
    s_iv[1] = 1'b1; s_ia[1] = 5'd4; s_fl[1] = 1'b1;
    pin(1, 2, 32'h10, 1'b1);
    step();
    pin(1, 2, 32'h10, 1'b0);

    // Four independent read ports, one busy, one on r0 under a discarded write
    step();
    s_iv[1] = 1'b1; s_ia[1] = 5'd9;
    step();
    s_we[1][0] = 1'b1; s_wa[1][0] = 5'd0; s_wd[1][0] = 32'hFFFFFFFF;
    s_ra[1][0] = 5'd0; s_ra[1][1] = 5'd7; s_ra[1][2] = 5'd9; s_ra[1][3] = 5'd4;
    pin(1, 0, 32'h0, 1'b0);
    pin(1, 1, 32'h22, 1'b0);
    pin(1, 2, 32'h55, 1'b1);
    pin(1, 3, 32'h10, 1'b0);

    // Asynchronous reset mid-cycle clears reads without a clock edge
    step();
    s_we[0][0] = 1'b1; s_wa[0][0] = 5'd5; s_wd[0][0] = 32'h1234;
    s_we[1][0] = 1'b1; s_wa[1][0] = 5'd5; s_wd[1][0] = 32'h1234;
    step();
    s_ra[0][0] = 5'd5; s_ra[1][0] = 5'd5;
    pin(0, 0, 32'h1234, 1'b0); pin(1, 0, 32'h1234, 1'b0);
    s_ra[1][1] = 5'd9; pin(1, 1, 32'h55, 1'b1);
    step();
    #2;
    resetn = 1'b0;
    pin(0, 0, 32'h0, 1'b0); pin(1, 0, 32'h0, 1'b0); pin(1, 1, 32'h0, 1'b0);
    step();
    resetn = 1'b1;
    pin(0, 0, 32'h0, 1'b0); pin(1, 0, 32'h0, 1'b0); pin(1, 1, 32'h0, 1'b0);

    // Random traffic, addresses biased to a small window for collisions
    repeat (600) begin
      step();
      for (int d = 0; d < 2; d++) begin
        for (int j = 0; j < nw_of(d); j++) begin
          s_we[d][j] = ($urandom_range(0, 2) != 0);
          s_wa[d][j] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
          s_wd[d][j] = $urandom;
        end
        for (int i = 0; i < nr_of(d); i++) begin
          if ($urandom_range(0, 3) == 0) s_ra[d][i] = s_wa[d][$urandom_range(0, nw_of(d) - 1)];
          else s_ra[d][i] = AW'($urandom_range(0, 7));
        end
        s_iv[d] = ($urandom_range(0, 3) == 0);
        s_ia[d] = AW'($urandom_range(0, 7));
        s_fl[d] = ($urandom_range(0, 19) == 0);
      end
    end

    step();
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined MIPS core.
- Generalises width, depth, read-port count and write-port count.
- Adds an optional same-cycle write-to-read bypass and a per-register busy scoreboard so decode can stall on pending multi-cycle producers (mul/div, loads).
- Sits between decode (reads, issue) and writeback (writes, busy clear).

Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero
- NR, 2, number of read ports
- NW, 1, number of write ports
- BYPASS, 1, 1 = read ports see same-cycle write data; 0 = read ports see only committed state
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- ra  in  NR*AW  read addresses; port i at [i*AW +: AW]
- rd  out  NR*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NR  1 = register at ra[i] has a pending producer
- we  in  NW  write enables
- wa  in  NW*AW  write addresses
- wd  in  NW*DATA_W  write data
- issue_valid  in  1  mark issue_addr busy at the next edge
- issue_addr  in  AW  destination of the issued multi-cycle instruction
- flush  in  1  clear all busy bits at the next edge (pipeline flush)

Behaviour:
- Reset (resetn=0, asynchronous): all registers = 0, all busy bits = 0. Reads are combinational, so rd = 0 and rd_busy = 0 while reset is held. Deassertion takes effect at the next clk edge.
- Register 0:
  - Reads always return 0 and rd_busy = 0.
  - Writes to it are discarded.
  - issue_valid with issue_addr = 0 is ignored.
- Write:
  - At the rising edge, regs[wa[j]] <= wd[j] for each j with we[j]=1.
  - Same address on several enabled ports: the highest port index wins.
- Read:
  - Combinational, zero latency.
  - BYPASS=1: if any enabled write port targets ra[i] (ra[i] != 0), rd[i] = wd of the highest-index matching port; otherwise the stored value.
  - BYPASS=0: rd[i] = stored value; new data is visible the cycle after the write edge.
- Busy scoreboard (one bit per register 1..NREGS-1), next-state priority per register r, highest first:
  1. flush=1 -> 0, for every r, overriding issue and writes.
  2. issue_valid=1 and issue_addr=r -> 1. Issue wins over a same-cycle write to r, because the new producer is younger.
  3. Any enabled write with wa=r -> 0.
  4. Otherwise hold.
- rd_busy:
  - rd_busy[i] = busy[ra[i]] from the registered bits.
  - BYPASS=1: a same-cycle enabled write to ra[i] also forces rd_busy[i]=0, since the value is being supplied.
- Data writes during flush still commit; flush affects busy bits only.
- No X propagation: out-of-range addresses are impossible because NREGS is a power of two.

Test Plan:
- Reset: hold resetn=0 mid-run after writing r5=0x1234 -> rd for ra=5 is 0 and rd_busy=0 immediately, without a clock edge.
- Write/read, BYPASS=0: write r3=0xDEADBEEF at edge N, read ra=3 in the same cycle -> old value (0). In cycle N+1 -> 0xDEADBEEF. Write r0=0xFFFFFFFF -> ra=0 reads 0.
- Bypass, BYPASS=1, NW=2: we=2'b11, wa[0]=wa[1]=7, wd[0]=0x11, wd[1]=0x22, read ra=7 same cycle -> 0x22. After the edge, stored r7=0x22.
- Scoreboard: issue r9 at edge N -> rd_busy=1 for ra=9 from N+1. Write r9=0x55 at edge N+3 -> with BYPASS=1, rd_busy=0 and rd=0x55 in that cycle; busy cleared from N+4.
- Simultaneous events: in one cycle, issue r4 and write r4=0x10 -> after the edge r4=0x10 and busy[4]=1. Next cycle, issue r4 with flush=1 -> busy[4]=0.
- Multi-port: NR=4; read four distinct registers, including r0 and a busy one -> each port returns its own value and busy flag independently.
